// File: rtl/hit_detector_pkg.sv
// rtl/hit_detector_pkg.sv - shared VGA timing, colour and state definitions for the hit/HP stages
package hit_detector_pkg;

    localparam int COORD_W = 12;
    localparam int RGB_W   = 12;

    localparam int H_VISIBLE = 800;
    localparam int H_TOTAL   = 1056;
    localparam int V_VISIBLE = 600;
    localparam int V_TOTAL   = 628;

    localparam logic [RGB_W-1:0] COLOR_BLACK    = 12'h000;
    localparam logic [RGB_W-1:0] COLOR_RED      = 12'hf00;
    localparam logic [RGB_W-1:0] COLOR_GREEN    = 12'h0f0;
    localparam logic [RGB_W-1:0] OBSTACLE_COLOR = COLOR_RED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        INVULN = 2'd2
    } state_t;

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational test of a pixel against a square box
module box_overlap
    import hit_detector_pkg::*;
(
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] box_x,
    input  logic [COORD_W-1:0] box_y,
    input  logic [COORD_W-1:0] box_size,
    output logic               in_box
);

    // One extra bit on the far edges keeps a box near the top of the range from wrapping.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end  = {1'b0, box_x} + {1'b0, box_size};
    assign y_end  = {1'b0, box_y} + {1'b0, box_size};
    assign in_box = (px >= box_x) && ({1'b0, px} < x_end) &&
                    (py >= box_y) && ({1'b0, py} < y_end);

endmodule

// File: rtl/hit_detector.sv
// rtl/hit_detector.sv - per-frame player hit detection with invulnerability window
module hit_detector
    import hit_detector_pkg::*;
#(
    parameter int          PLAYER_SIZE    = 20,
    parameter logic [11:0] OBSTACLE_COLOR = hit_detector_pkg::OBSTACLE_COLOR,
    parameter int          INVULN_FRAMES  = 60,
    parameter int          MAX_HITS       = 5
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        game_on,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        player_hit,
    output logic        invuln
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ARMED  = ARMED;
    localparam logic [1:0] S_INVULN = INVULN;
    localparam int         HW       = $clog2(MAX_HITS + 1);

    logic [1:0]    state;
    logic          vblnk_prev;
    logic          hit_pending;
    logic [HW-1:0] hit_cnt;
    logic [7:0]    frame_cnt;
    logic          in_box;
    logic          visible;
    logic          overlap;
    logic          frame_end;

    box_overlap u_box (
        .px       (hcount_in),
        .py       (vcount_in),
        .box_x    (player_x),
        .box_y    (player_y),
        .box_size (COORD_W'(PLAYER_SIZE)),
        .in_box   (in_box)
    );

    assign visible   = !hblnk_in && !vblnk_in;
    assign overlap   = visible && (rgb_in == OBSTACLE_COLOR) && in_box;
    assign frame_end = vblnk_in && !vblnk_prev;

    // Delay the timing signals and colour by one cycle to match the registered hit outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_in;
        end
    end

    // Remember vblank so its rising edge marks the end of each frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
        end
    end

    // Collect overlaps within one frame; the frame end consumes or discards them.
    always_ff @(posedge pclk) begin
        if (rst || !game_on || state == S_IDLE) begin
            hit_pending <= 1'b0;
        end else if (frame_end) begin
            hit_pending <= 1'b0;
        end else if (overlap) begin
            hit_pending <= 1'b1;
        end
    end

    // Hit FSM: issue a pulse per frame with a hit, then ignore hits for INVULN_FRAMES frame ends.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= S_IDLE;
            player_hit <= 1'b0;
            invuln     <= 1'b0;
            hit_cnt    <= '0;
            frame_cnt  <= '0;
        end else begin
            player_hit <= 1'b0;
            if (!game_on) begin
                state     <= S_IDLE;
                invuln    <= 1'b0;
                hit_cnt   <= '0;
                frame_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (frame_end && hit_pending && (hit_cnt < HW'(MAX_HITS))) begin
                            player_hit <= 1'b1;
                            invuln     <= 1'b1;
                            hit_cnt    <= hit_cnt + HW'(1);
                            frame_cnt  <= 8'(INVULN_FRAMES);
                            state      <= S_INVULN;
                        end
                    end
                    S_INVULN: begin
                        if (frame_end) begin
                            frame_cnt <= frame_cnt - 8'd1;
                            if (frame_cnt == 8'd1) begin
                                invuln <= 1'b0;
                                state  <= S_ARMED;
                            end
                        end
                    end
                    default: begin
                        invuln <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hit_detector.sv
// tb/tb_hit_detector.sv - directed self-checking bench for hit_detector
module tb_hit_detector;

    logic        pclk = 1'b0;
    logic        rst;
    logic        game_on;
    logic [11:0] player_x;
    logic [11:0] player_y;
    logic [11:0] hcount_in;
    logic [11:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;

    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out, player_hit, invuln;
    logic [11:0] hcount_out_s, vcount_out_s, rgb_out_s;
    logic        hsync_out_s, vsync_out_s, hblnk_out_s, vblnk_out_s, player_hit_s, invuln_s;

    int vec  = 0;
    int errs = 0;
    int pulse_main;
    int pulse_sat;
    bit aligned;

    always #5 pclk = ~pclk;

    hit_detector #(.PLAYER_SIZE(20), .OBSTACLE_COLOR(12'hf00), .INVULN_FRAMES(3), .MAX_HITS(5)) dut (
        .pclk(pclk), .rst(rst), .game_on(game_on), .player_x(player_x), .player_y(player_y),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
        .player_hit(player_hit), .invuln(invuln)
    );

    hit_detector #(.PLAYER_SIZE(20), .OBSTACLE_COLOR(12'hf00), .INVULN_FRAMES(1), .MAX_HITS(5)) dut_sat (
        .pclk(pclk), .rst(rst), .game_on(game_on), .player_x(player_x), .player_y(player_y),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out_s), .vcount_out(vcount_out_s), .hsync_out(hsync_out_s), .vsync_out(vsync_out_s),
        .hblnk_out(hblnk_out_s), .vblnk_out(vblnk_out_s), .rgb_out(rgb_out_s),
        .player_hit(player_hit_s), .invuln(invuln_s)
    );

    task automatic step();
        @(posedge pclk);
        #1;
        if (player_hit === 1'b1) pulse_main++;
        if (player_hit_s === 1'b1) pulse_sat++;
    endtask

    task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic hb, input logic vb,
                         input logic [11:0] rgb);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hb;
        vsync_in  = vb;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        game_on  = 1'b0;
        player_x = 12'd400;
        player_y = 12'd400;
        drive(12'd0, 12'd0, 1'b0, 1'b0, 12'h000);
        step();
        step();
        rst     = 1'b0;
        game_on = 1'b1;
        step();
        pulse_main = 0;
        pulse_sat  = 0;
    endtask

    task automatic visible_part(input bit hit, input logic [11:0] hx, input logic [11:0] hy);
        for (int i = 0; i < 4; i++) begin
            drive(12'(100 + i), 12'd100, 1'b0, 1'b0, 12'hf00);
            step();
        end
        drive(hx, hy, 1'b0, 1'b0, hit ? 12'hf00 : 12'h0f0);
        step();
    endtask

    task automatic run_frame(input bit hit, input logic [11:0] hx, input logic [11:0] hy);
        visible_part(hit, hx, hy);
        aligned = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(12'd0, 12'd600, 1'b1, 1'b1, 12'h000);
            step();
            if (i == 0 && player_hit === 1'b1 && vblnk_out === 1'b1) aligned = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        game_on = 1'b1;
        drive(12'habc, 12'h123, 1'b1, 1'b1, 12'hf00);
        step();
        step();
        vec++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, player_hit, invuln} !== 42'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %h want 0",
                     {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, player_hit, invuln});
        end
        vec++;
        if (dut.state !== 2'd0 || dut.hit_cnt !== '0 || dut.frame_cnt !== 8'd0) begin
            errs++;
            $display("FAIL reset_state: state=%0d hit_cnt=%0d frame_cnt=%0d want 0/0/0",
                     dut.state, dut.hit_cnt, dut.frame_cnt);
        end
    endtask

    task automatic test_basic_hit();
        do_reset();
        run_frame(1'b1, 12'd405, 12'd410);
        vec++;
        if (pulse_main != 1) begin errs++; $display("FAIL basic_pulses: got %0d want 1", pulse_main); end
        vec++;
        if (aligned !== 1'b1) begin errs++; $display("FAIL basic_align: got %0b want 1", aligned); end
        vec++;
        if (invuln !== 1'b1) begin errs++; $display("FAIL basic_invuln: got %0b want 1", invuln); end
        do_reset();
        run_frame(1'b0, 12'd405, 12'd410);
        vec++;
        if (pulse_main != 0) begin errs++; $display("FAIL wrong_colour: got %0d pulses want 0", pulse_main); end
    endtask

    task automatic test_edge_pixels();
        logic [11:0] ex [4] = '{12'd419, 12'd420, 12'd400, 12'd399};
        logic [11:0] ey [4] = '{12'd419, 12'd400, 12'd420, 12'd400};
        int          ep [4] = '{1, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            run_frame(1'b1, ex[k], ey[k]);
            vec++;
            if (pulse_main != ep[k]) begin
                errs++;
                $display("FAIL edge_%0d_%0d: got %0d pulses want %0d", ex[k], ey[k], pulse_main, ep[k]);
            end
        end
    endtask

    task automatic test_invuln_window();
        int exp_p [6] = '{1, 0, 0, 0, 1, 0};
        bit exp_i [6] = '{1, 1, 1, 0, 1, 1};
        do_reset();
        for (int f = 0; f < 6; f++) begin
            pulse_main = 0;
            run_frame(1'b1, 12'd405, 12'd410);
            vec++;
            if (pulse_main != exp_p[f]) begin
                errs++;
                $display("FAIL window_pulse_f%0d: got %0d want %0d", f, pulse_main, exp_p[f]);
            end
            vec++;
            if (invuln !== exp_i[f]) begin
                errs++;
                $display("FAIL window_invuln_f%0d: got %0b want %0b", f, invuln, exp_i[f]);
            end
        end
    endtask

    task automatic test_saturation();
        int late;
        do_reset();
        for (int f = 0; f < 10; f++) run_frame(1'b1, 12'd405, 12'd410);
        late = pulse_sat;
        for (int f = 10; f < 14; f++) run_frame(1'b1, 12'd405, 12'd410);
        vec++;
        if (pulse_sat != 5) begin errs++; $display("FAIL sat_total: got %0d want 5", pulse_sat); end
        vec++;
        if (pulse_sat != late) begin errs++; $display("FAIL sat_after_max: got %0d extra want 0", pulse_sat - late); end
        vec++;
        if (pulse_main != 4) begin errs++; $display("FAIL sat_main_n3: got %0d want 4", pulse_main); end
        game_on = 1'b0;
        step();
        game_on = 1'b1;
        step();
        pulse_sat = 0;
        run_frame(1'b1, 12'd405, 12'd410);
        vec++;
        if (pulse_sat != 1) begin errs++; $display("FAIL sat_restart: got %0d want 1", pulse_sat); end
    endtask

    task automatic test_abort();
        do_reset();
        visible_part(1'b1, 12'd405, 12'd410);
        vec++;
        if (dut.hit_pending !== 1'b1) begin errs++; $display("FAIL abort_pending: got %0b want 1", dut.hit_pending); end
        drive(12'd0, 12'd600, 1'b1, 1'b1, 12'h000);
        game_on = 1'b0;
        step();
        vec++;
        if (player_hit !== 1'b0 || invuln !== 1'b0) begin
            errs++;
            $display("FAIL abort_outputs: hit=%0b invuln=%0b want 0/0", player_hit, invuln);
        end
        vec++;
        if (dut.hit_cnt !== '0 || dut.state !== 2'd0) begin
            errs++;
            $display("FAIL abort_state: hit_cnt=%0d state=%0d want 0/0", dut.hit_cnt, dut.state);
        end
        step();
        step();
        vec++;
        if (pulse_main != 0) begin errs++; $display("FAIL abort_no_pulse: got %0d want 0", pulse_main); end
    endtask

    task automatic test_passthrough_reset();
        logic [39:0] expv;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            hcount_in = 12'($urandom);
            vcount_in = 12'($urandom);
            hsync_in  = 1'($urandom);
            vsync_in  = 1'($urandom);
            hblnk_in  = 1'($urandom);
            vblnk_in  = 1'($urandom);
            rgb_in    = 12'($urandom);
            expv = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
            step();
            vec++;
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== expv) begin
                errs++;
                $display("FAIL passthrough_c%0d: got %h want %h", c,
                         {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, expv);
            end
        end
        do_reset();
        run_frame(1'b1, 12'd405, 12'd410);
        vec++;
        if (invuln !== 1'b1) begin errs++; $display("FAIL midinvuln_pre: got %0b want 1", invuln); end
        drive(12'h7ff, 12'h3ff, 1'b1, 1'b1, 12'hfff);
        rst = 1'b1;
        step();
        vec++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, player_hit, invuln} !== 42'd0) begin
            errs++;
            $display("FAIL midinvuln_outputs: got %h want 0",
                     {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, player_hit, invuln});
        end
        vec++;
        if (dut.state !== 2'd0) begin errs++; $display("FAIL midinvuln_state: got %0d want 0", dut.state); end
        rst = 1'b0;
    endtask

    initial begin
        pulse_main = 0;
        pulse_sat  = 0;
        test_reset();
        test_basic_hit();
        test_edge_pixels();
        test_invuln_window();
        test_saturation();
        test_abort();
        test_passthrough_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hit_detector.md
# hit_detector

Upstream companion of the HP bar stage. It scans each visible pixel and flags a hit when obstacle-coloured pixels overlap the player's bounding box. It emits at most one single-cycle `player_hit` pulse per frame, then holds an invulnerability window of a set number of frames. VGA timing and RGB pass through with one-cycle latency, so the HP stage can be chained directly after it.

## Interface
Parameters:
- `PLAYER_SIZE`, 20: side of the square player box, in pixels.
- `OBSTACLE_COLOR`, 12'hf_0_0: RGB value that counts as an obstacle.
- `INVULN_FRAMES`, 60: number of frames hits are ignored after a hit; legal range 1..255.
- `MAX_HITS`, 5: after this many pulses, no further pulses until the game restarts.

Ports:
- `pclk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high.
- `game_on` in 1: game active; low forces IDLE.
- `player_x`, `player_y` in 12 each: top-left corner of the player box; sampled every cycle.
- `hcount_in`, `vcount_in` in 12 each: pixel counters.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1 each: timing signals.
- `rgb_in` in 12: pixel colour from the obstacle layer.
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`, `rgb_out`: the same signals delayed by one cycle, unmodified.
- `player_hit` out 1: one-cycle pulse per accepted hit; connects to the HP stage.
- `invuln` out 1: high while the invulnerability window is running.

## Operation
- Visible pixel: `hblnk_in`=0 and `vblnk_in`=0.
- Overlap: visible, `rgb_in`==`OBSTACLE_COLOR`, `player_x` ≤ `hcount_in` < `player_x`+`PLAYER_SIZE`, and `player_y` ≤ `vcount_in` < `player_y`+`PLAYER_SIZE`.
- Comparisons use 13-bit sums, so a box near 4095 does not wrap.
- `hit_pending` register: set on any overlap; cleared at every frame end.
- Frame end (`frame_end`): `vblnk_in`=1 and registered `vblnk_prev`=0.
- IDLE:
  - `player_hit`=0, `invuln`=0, `hit_cnt`=0, `frame_cnt`=0, `hit_pending` held at 0.
  - Goes to ARMED when `game_on`=1.
- ARMED:
  - On `frame_end` with `hit_pending`=1 and `hit_cnt`<`MAX_HITS`: pulse `player_hit`, increment `hit_cnt`, load `frame_cnt`=`INVULN_FRAMES`, go to INVULN.
  - With `hit_cnt`==`MAX_HITS`: stay in ARMED and emit no pulse.
- INVULN:
  - `invuln`=1.
  - Each `frame_end` decrements `frame_cnt`; `hit_pending` is discarded.
  - When `frame_cnt` reaches 0, go to ARMED. That `frame_end` is also the one that ends the window; pixels of the following frame are evaluated normally.
- `game_on`=0 in any state: go to IDLE on the next edge and clear all counters. No pulse is issued on that cycle, even if a `frame_end` coincides.
- `rst` overrides everything.
- Overlap and `frame_end` cannot coincide, because blanking excludes visible pixels. An overlap on the last visible pixel before `frame_end` still counts for that frame.

## Timing
- Reset values: every output 0; state IDLE; `vblnk_prev`=0; `hit_pending`=0; `hit_cnt`=0; `frame_cnt`=0.
- Pass-through latency: exactly 1 cycle for all timing signals and `rgb`.
- `player_hit` is registered. It is high during the cycle after the `frame_end` edge, for exactly 1 cycle, and therefore aligns with the delayed `vblnk_out` rising edge.
- `invuln` is registered and goes high on the same cycle as `player_hit`.
- It falls the cycle after the `frame_end` at which `frame_cnt` reaches 0. For `INVULN_FRAMES`=N, the window therefore covers N frame ends.
- Pulse rate: at most one pulse per N+1 frames; at most `MAX_HITS` pulses per game.
- Rising `game_on`: ARMED from the next cycle; overlaps already in the current frame count.

## Structure
- Shared package: VGA timing constants, colour constants including `OBSTACLE_COLOR`, and a 2-bit state enum (IDLE=0, ARMED=1, INVULN=2). The HP stage uses the same colour constants.
- One natural sub-module, `box_overlap`: purely combinational. It takes the pixel coordinates, box origin and size, and returns an in-box flag. The 13-bit compare lives here so the HP stage can reuse it.
- Everything else (edge detect, FSM, counters, pass-through registers) lives in `hit_detector`.

## Test plan
- Basic hit:
  - Stimulus: `rst`, then `game_on`=1; player at (400,400); one `rgb_in`=f00 pixel at (405,410) in frame 0.
  - Response: one `player_hit` pulse, one cycle after `vblnk_in` rises; `invuln`=1.
- Edge pixels:
  - Stimulus: f00 at (419,419), then in another run at (420,400), with `PLAYER_SIZE`=20.
  - Response: first run pulses; second run gives no pulse.
- Invulnerability window:
  - Stimulus: `INVULN_FRAMES`=3; overlap in every frame.
  - Response: pulses at the ends of frames 0 and 4 only; `invuln` falls after the frame 3 end.
- Saturation:
  - Stimulus: `MAX_HITS`=5, `INVULN_FRAMES`=1; overlap every frame.
  - Response: exactly 5 pulses, then none; toggling `game_on` 0→1 re-enables pulses.
- Abort:
  - Stimulus: `game_on` dropped on the same cycle as `frame_end` with `hit_pending`=1.
  - Response: no pulse; `invuln`=0; `hit_cnt`=0 next cycle.
- Pass-through and reset:
  - Stimulus: random timing signals and `rgb`; `rst` asserted mid-INVULN.
  - Response: outputs equal the inputs delayed by 1 cycle; after `rst`, all outputs are 0 and state is IDLE.
